vga_scan_driver: RTL

Display-side timing generator for the Pong GUI. It produces the `row`/`col` scan coordinates that the menu, paddle, ball and score renderers decode, and collects the OR-ed pixel they return on `rgb_in`. It drives registered, aligned `rgb`/`hsync`/`vsync` to the VGA connector. It also emits a once-per-frame tick that game and menu logic use as their update strobe.

---
 rtl/vga_scan_driver.sv | 105 ++++++++++
 1 files changed

// File: rtl/vga_scan_driver.sv
// VGA scan timing generator: pixel divider, col/row scan counters, registered
// rgb/hsync/vsync output stage and a once-per-frame update strobe.
module vga_scan_driver #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter int unsigned CLOCK_DIV = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] rgb_in,
  output logic [9:0] row,
  output logic [9:0] col,
  output logic       visible,
  output logic       pixel_tick,
  output logic       hsync,
  output logic       vsync,
  output logic [2:0] rgb,
  output logic       frame_tick
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned DIV_W   = (CLOCK_DIV > 1) ? $clog2(CLOCK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLOCK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] V_VIS_LAST = 10'(V_VISIBLE - 1);
  localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       col_q, col_d;
  logic [9:0]       row_q, row_d;
  logic [2:0]       rgb_q, rgb_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             frame_tick_q, frame_tick_d;

  // With CLOCK_DIV=1 the divider is stuck at 0 == DIV_LAST, so the tick is constant.
  assign pixel_tick = (div_q == DIV_LAST);
  assign visible    = (col_q < H_VIS) && (row_q < V_VIS);

  always_comb begin
    div_d        = pixel_tick ? '0 : div_q + DIV_ONE;
    col_d        = col_q;
    row_d        = row_q;
    rgb_d        = rgb_q;
    hsync_d      = hsync_q;
    vsync_d      = vsync_q;
    frame_tick_d = 1'b0;
    if (pixel_tick) begin
      if (col_q == H_LAST) begin
        col_d = '0;
        row_d = (row_q == V_LAST) ? '0 : row_q + 10'd1;
      end else begin
        col_d = col_q + 10'd1;
      end
      // Output stage samples the pre-increment coordinates: one pixel of latency.
      rgb_d        = visible ? rgb_in : '0;
      hsync_d      = !((col_q >= HS_START) && (col_q < HS_END));
      vsync_d      = !((row_q >= VS_START) && (row_q < VS_END));
      frame_tick_d = (col_q == H_LAST) && (row_q == V_VIS_LAST);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      div_q        <= '0;
      col_q        <= '0;
      row_q        <= '0;
      rgb_q        <= '0;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      div_q        <= div_d;
      col_q        <= col_d;
      row_q        <= row_d;
      rgb_q        <= rgb_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign col        = col_q;
  assign row        = row_q;
  assign rgb        = rgb_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign frame_tick = frame_tick_q;

endmodule
